// File: rtl/seven_seg_scan_if.sv
// Bundle of the score-register side inputs and the display-pin side outputs
// of the multiplexed seven-segment driver.
interface seven_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [3:0]          brightness;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output value, dp_in, load, blank_lz, brightness,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, load, blank_lz, brightness,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver: scans DIGITS digits over one shared
// segment bus, double-buffers the shown value so a frame never tears, blanks
// leading zeros, and dims the display with a 16-step PWM inside each slot.
module seven_seg_scan #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int SUB_DIV = REFRESH_DIV / 16;
    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W   = 4 * DIGITS;

    localparam logic              SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic              AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF   = {7{SEG_INV}};
    localparam logic              DP_OFF    = SEG_INV;
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_INV}};
    localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  SUB_DIV_C = CNT_W'(SUB_DIV);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    // Hex nibble to active-high gfedcba segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h67;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [VAL_W-1:0]  pend_val_r;
    logic [DIGITS-1:0] pend_dp_r;
    logic              pend_valid_r;
    logic [VAL_W-1:0]  act_val_r;
    logic [DIGITS-1:0] act_dp_r;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] an_r;
    logic              frame_done_r;

    logic              frame_end_s;
    logic [CNT_W-1:0]  thr_s;
    logic              pwm_on_s;
    logic [3:0]        nib_s [DIGITS];
    logic [DIGITS-1:0] blank_s;
    logic              zero_run_s;
    logic [3:0]        cur_nib_s;
    logic [DIGITS-1:0] onehot_s;
    logic [6:0]        seg_n_s;
    logic              dp_n_s;
    logic [DIGITS-1:0] an_n_s;

    assign frame_end_s = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);

    // sub-phase < brightness is the same as cnt < brightness*SUB_DIV, which
    // avoids a divider; the product always fits because brightness <= 15.
    assign thr_s    = CNT_W'(bus.brightness) * SUB_DIV_C;
    assign pwm_on_s = (cnt_r < thr_s);
    assign onehot_s = AN_ONE << idx_r;

    // Slot counter and digit index: cnt runs through one slot, idx steps per slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (idx_r == IDX_LAST) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Pending/active value pair: loads land in pending, which is promoted to
    // active only at frame end; a load on the frame-end cycle goes straight in.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val_r   <= '0;
            pend_dp_r    <= '0;
            pend_valid_r <= 1'b0;
            act_val_r    <= '0;
            act_dp_r     <= '0;
        end else if (frame_end_s) begin
            pend_valid_r <= 1'b0;
            if (bus.load) begin
                pend_val_r <= bus.value;
                pend_dp_r  <= bus.dp_in;
                act_val_r  <= bus.value;
                act_dp_r   <= bus.dp_in;
            end else if (pend_valid_r) begin
                act_val_r <= pend_val_r;
                act_dp_r  <= pend_dp_r;
            end
        end else if (bus.load) begin
            pend_val_r   <= bus.value;
            pend_dp_r    <= bus.dp_in;
            pend_valid_r <= 1'b1;
        end
    end

    // Split active value into nibbles and mark digits that sit in a run of
    // zeros reaching the top digit; digit 0 is never marked.
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_s[i] = act_val_r[i*4 +: 4];
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (nib_s[i] == 4'h0);
            blank_s[i] = zero_run_s & (i != 0);
        end
    end

    assign cur_nib_s = nib_s[idx_r];

    // Next pin levels: everything inactive unless the PWM window is open, so
    // segments never ghost onto a dark digit.
    always_comb begin
        seg_n_s = SEG_OFF;
        dp_n_s  = DP_OFF;
        an_n_s  = AN_OFF;
        if (pwm_on_s) begin
            an_n_s = onehot_s ^ AN_OFF;
            dp_n_s = act_dp_r[idx_r] ^ DP_OFF;
            if (bus.blank_lz && blank_s[idx_r]) begin
                seg_n_s = SEG_OFF;
            end else begin
                seg_n_s = hex_to_seg(cur_nib_s) ^ SEG_OFF;
            end
        end else begin
            seg_n_s = SEG_OFF;
            dp_n_s  = DP_OFF;
            an_n_s  = AN_OFF;
        end
    end

    // Output registers; a single registered one-hot vector guarantees no
    // anode overlap at slot boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_n_s;
            dp_r         <= dp_n_s;
            an_r         <= an_n_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.an         = an_r;
    assign bus.frame_done = frame_done_r;
endmodule
